// File: rtl/leve1_axir_arb.sv
// leve1_axir_arb: shares one single-beat AXI read initiator between fetch (s0) and load (s1) ports.
// Optional LEVE1_ARB_FIXED_PRIO_EN: load port always wins a tie; default build is round-robin.
`ifndef XLEN
`define XLEN 32
`endif

module leve1_axir_arb #(
    parameter int AW = `XLEN,
    parameter int DW = `XLEN
) (
    input  logic          clk,
    input  logic          rst_n,
    // fetch port
    input  logic          s0_arvalid,
    output logic          s0_arready,
    input  logic [AW-1:0] s0_araddr,
    output logic          s0_rvalid,
    input  logic          s0_rready,
    output logic [DW-1:0] s0_rdata,
    output logic [1:0]    s0_rresp,
    // load port
    input  logic          s1_arvalid,
    output logic          s1_arready,
    input  logic [AW-1:0] s1_araddr,
    output logic          s1_rvalid,
    input  logic          s1_rready,
    output logic [DW-1:0] s1_rdata,
    output logic [1:0]    s1_rresp,
    // shared initiator
    output logic          m_arvalid,
    input  logic          m_arready,
    output logic [AW-1:0] m_araddr,
    input  logic          m_rvalid,
    output logic          m_rready,
    input  logic [DW-1:0] m_rdata,
    input  logic [1:0]    m_rresp,
    // debug
    output logic          gnt_id,
    output logic [1:0]    fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends on ready, and a requester holds valid/address until accepted.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   req_any;
    logic   winner;
    logic   accept;
    logic   rready_sel;

    assign req_any   = s0_arvalid | s1_arvalid;
    assign accept    = (state == IDLE) & req_any;
    assign fsm_state = state;

`ifdef LEVE1_ARB_FIXED_PRIO_EN
    // Load wins whenever it asks; fetch only gets a lone request through.
    assign winner = s1_arvalid;
`else
    logic last;

    assign winner = (s0_arvalid && s1_arvalid) ? ~last : s1_arvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= winner;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_id   <= 1'b0;
            m_araddr <= '0;
        end else if (accept) begin
            gnt_id   <= winner;
            m_araddr <= winner ? s1_araddr : s0_araddr;
        end
    end

    assign rready_sel = gnt_id ? s1_rready : s0_rready;

    always_comb begin
        state_nxt  = state;
        s0_arready = 1'b0;
        s1_arready = 1'b0;
        s0_rvalid  = 1'b0;
        s1_rvalid  = 1'b0;
        s0_rdata   = '0;
        s1_rdata   = '0;
        s0_rresp   = 2'b00;
        s1_rresp   = 2'b00;
        m_arvalid  = 1'b0;
        m_rready   = 1'b0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    s0_arready = ~winner;
                    s1_arready = winner;
                    state_nxt  = ADDR;
                end
            end
            ADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                // Data and response go to both ports; only the owner sees valid.
                m_rready  = rready_sel;
                s0_rvalid = m_rvalid & ~gnt_id;
                s1_rvalid = m_rvalid & gnt_id;
                s0_rdata  = m_rdata;
                s1_rdata  = m_rdata;
                s0_rresp  = m_rresp;
                s1_rresp  = m_rresp;
                if (m_rvalid && rready_sel) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_leve1_axir_arb.sv
// tb_leve1_axir_arb: directed corner cases plus randomized traffic checked by a scoreboard
// against a transaction-level arbitration model.
module tb_leve1_axir_arb;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef LEVE1_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s0_arvalid, s0_arready, s0_rvalid, s0_rready;
    logic [AW-1:0] s0_araddr;
    logic [DW-1:0] s0_rdata;
    logic [1:0]    s0_rresp;
    logic          s1_arvalid, s1_arready, s1_rvalid, s1_rready;
    logic [AW-1:0] s1_araddr;
    logic [DW-1:0] s1_rdata;
    logic [1:0]    s1_rresp;
    logic          m_arvalid, m_arready, m_rvalid, m_rready;
    logic [AW-1:0] m_araddr;
    logic [DW-1:0] m_rdata;
    logic [1:0]    m_rresp;
    logic          gnt_id;
    logic [1:0]    fsm_state;

    leve1_axir_arb #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr),
        .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
        .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr),
        .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .gnt_id(gnt_id), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [DW+1:0] exp_q0[$];
    logic [DW+1:0] exp_q1[$];
    logic [AW-1:0] addr_q[$];
    bit            mon_en = 1'b0;
    bit            busy0, busy1;
    bit            model_busy, model_last, model_owner;
    bit            slv_pend;
    logic [AW-1:0] slv_addr;

    // Slave memory model: data and response derived from the address.
    function automatic logic [DW+1:0] resp_of(input logic [AW-1:0] a);
        return {a[3:2], a ^ 32'h5A5A_C3C3};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event with no expected entry", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        s0_arvalid = 0; s0_araddr = '0; s0_rready = 0;
        s1_arvalid = 0; s1_araddr = '0; s1_rready = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = 2'b00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor / scoreboard: model of the arbitration rules at transaction level.
    always @(negedge clk) begin
        if (mon_en) begin
            if (m_arvalid && m_arready) begin
                if (addr_q.size() == 0) fail("m_araddr");
                else check("m_araddr", m_araddr, addr_q.pop_front());
            end
            if (!model_busy) begin
                if (s0_arvalid || s1_arvalid) begin
                    bit w;
                    if (s0_arvalid && s1_arvalid) w = FIXED ? 1'b1 : !model_last;
                    else w = s1_arvalid;
                    check("arready_grant", {s1_arready, s0_arready}, w ? 2'b10 : 2'b01);
                    addr_q.push_back(w ? s1_araddr : s0_araddr);
                    model_last  = w;
                    model_owner = w;
                    model_busy  = 1'b1;
                end else begin
                    check("arready_idle", {s1_arready, s0_arready}, 2'b00);
                end
            end else begin
                check("arready_busy", {s1_arready, s0_arready}, 2'b00);
                check("gnt_id", gnt_id, model_owner);
                if (s0_rvalid || s1_rvalid)
                    check("rvalid_route", {s1_rvalid, s0_rvalid}, model_owner ? 2'b10 : 2'b01);
                if (s0_rvalid && s0_rready) begin
                    if (exp_q0.size() == 0) fail("resp0");
                    else check("resp0", {s0_rresp, s0_rdata}, exp_q0.pop_front());
                    busy0 = 1'b0;
                    model_busy = 1'b0;
                end
                if (s1_rvalid && s1_rready) begin
                    if (exp_q1.size() == 0) fail("resp1");
                    else check("resp1", {s1_rresp, s1_rdata}, exp_q1.pop_front());
                    busy1 = 1'b0;
                    model_busy = 1'b0;
                end
            end
        end
    end

    // One randomized cycle: requesters, then slave reacting to sampled handshakes.
    task automatic rand_cycle(input bit allow_new);
        bit acc0, acc1, arhs, rhs;
        logic [AW-1:0] hs_addr;
        logic [AW-1:0] a;
        @(negedge clk);
        acc0 = s0_arvalid & s0_arready;
        acc1 = s1_arvalid & s1_arready;
        arhs = m_arvalid & m_arready;
        rhs  = m_rvalid & m_rready;
        hs_addr = m_araddr;
        tick();
        if (acc0) s0_arvalid = 1'b0;
        if (acc1) s1_arvalid = 1'b0;
        if (allow_new && !s0_arvalid && !busy0 && $urandom_range(0, 2) == 0) begin
            a = $urandom;
            s0_araddr = a; s0_arvalid = 1'b1; busy0 = 1'b1;
            exp_q0.push_back(resp_of(a));
        end
        if (allow_new && !s1_arvalid && !busy1 && $urandom_range(0, 2) == 0) begin
            a = $urandom;
            s1_araddr = a; s1_arvalid = 1'b1; busy1 = 1'b1;
            exp_q1.push_back(resp_of(a));
        end
        s0_rready = ($urandom_range(0, 3) != 0);
        s1_rready = ($urandom_range(0, 3) != 0);
        if (arhs) begin
            slv_pend = 1'b1;
            slv_addr = hs_addr;
        end
        if (rhs) begin
            slv_pend = 1'b0;
            m_rvalid = 1'b0;
        end
        m_arready = ($urandom_range(0, 2) != 0);
        if (slv_pend && !m_rvalid && $urandom_range(0, 2) == 0) begin
            m_rvalid = 1'b1;
            {m_rresp, m_rdata} = resp_of(slv_addr);
        end
        if (!m_rvalid) begin
            m_rdata = $urandom;
            m_rresp = 2'($urandom_range(0, 3));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_w[3];
        rst_n = 1'b1;
        clear_inputs();
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("rst_state", fsm_state, 2'd0);
        check("rst_gnt", gnt_id, 1'b0);
        check("rst_araddr", m_araddr, '0);
        check("rst_ctrl", {s0_arready, s0_rvalid, s1_arready, s1_rvalid, m_arvalid, m_rready}, 6'd0);
        tick();
        rst_n = 1'b1;

        // single fetch, slave always ready
        s0_arvalid = 1; s0_araddr = 32'h1000; s0_rready = 1;
        m_arready = 1; m_rvalid = 1; m_rdata = 32'h1234_5678;
        @(negedge clk);
        check("t1_accept", {s1_arready, s0_arready, m_arvalid}, 3'b010);
        tick(); s0_arvalid = 0;
        @(negedge clk);
        check("t1_addr", {m_arvalid, m_araddr}, {1'b1, 32'h1000});
        tick();
        @(negedge clk);
        check("t1_data", {s0_rvalid, s1_rvalid, m_rready, s0_rdata}, {3'b101, 32'h1234_5678});
        tick();
        @(negedge clk);
        check("t1_idle", {fsm_state, s0_rvalid}, 3'b000);

        // both requesting from reset
        do_reset();
        exp_w[0] = FIXED ? 1'b1 : 1'b0;
        exp_w[1] = 1'b1;
        exp_w[2] = FIXED ? 1'b1 : 1'b0;
        s0_arvalid = 1; s0_araddr = 32'h40; s1_arvalid = 1; s1_araddr = 32'h80;
        s0_rready = 1; s1_rready = 1; m_arready = 1; m_rvalid = 1; m_rdata = 32'h77;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t2_arready", {s1_arready, s0_arready}, exp_w[k] ? 2'b10 : 2'b01);
            tick();
            @(negedge clk);
            check("t2_gnt", {gnt_id, m_araddr}, {exp_w[k], exp_w[k] ? 32'h80 : 32'h40});
            tick();
            @(negedge clk);
            check("t2_rvalid", {s1_rvalid, s0_rvalid}, exp_w[k] ? 2'b10 : 2'b01);
            tick();
        end
        s0_arvalid = 0; s1_arvalid = 0;

        // slave stalls the address phase; fetch asks meanwhile and must wait
        s1_arvalid = 1; s1_araddr = 32'hABC0; m_arready = 0; m_rvalid = 0;
        @(negedge clk);
        check("t3_accept", s1_arready, 1'b1);
        tick(); s1_arvalid = 0; s0_arvalid = 1; s0_araddr = 32'h5550;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t3_hold", {m_arvalid, m_araddr, s0_arready, s1_arready}, {1'b1, 32'hABC0, 2'b00});
            tick();
        end
        m_arready = 1;
        @(negedge clk);
        check("t3_release", {fsm_state, m_arvalid}, 3'b011);
        tick();

        // owner holds rready low in the data phase
        s1_rready = 0; m_rvalid = 1; m_rdata = 32'hBEEF; m_rresp = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t4_stall", {fsm_state, m_rready, s1_rvalid}, 4'b1001);
            tick();
        end
        s1_rready = 1;
        @(negedge clk);
        check("t4_deliver", {m_rready, s1_rvalid, s1_rdata}, {2'b11, 32'hBEEF});
        tick();

        // held fetch served next, with an error response
        m_rresp = 2'b10; m_rdata = 32'hDEAD; s0_rready = 1;
        @(negedge clk);
        check("t5_accept", {s1_arready, s0_arready}, 2'b01);
        tick(); s0_arvalid = 0;
        @(negedge clk);
        check("t5_addr", m_araddr, 32'h5550);
        tick();
        @(negedge clk);
        check("t5_resp", {s0_rvalid, s0_rresp, s0_rdata}, {1'b1, 2'b10, 32'hDEAD});
        tick();
        @(negedge clk);
        check("t5_idle", fsm_state, 2'd0);

        // reset in the data phase
        s0_arvalid = 1; s0_araddr = 32'h2000; s0_rready = 0; m_rvalid = 1; m_rresp = 2'b00;
        tick(); s0_arvalid = 0;
        tick();
        @(negedge clk);
        check("t6_in_data", {fsm_state, s0_rvalid}, 3'b101);
        rst_n = 0; m_rvalid = 0;
        #1;
        check("t6_reset", {fsm_state, gnt_id, m_arvalid, m_rready, s0_rvalid, s0_arready, m_araddr},
              {7'd0, 32'd0});
        tick(); rst_n = 1;
        s1_arvalid = 1; s1_araddr = 32'h3000; s1_rready = 1; m_arready = 1; m_rvalid = 1;
        m_rdata = 32'hCAFE;
        @(negedge clk);
        check("t6_accept", s1_arready, 1'b1);
        tick(); s1_arvalid = 0;
        tick();
        @(negedge clk);
        check("t6_after", {s1_rvalid, s1_rdata, m_araddr}, {1'b1, 32'hCAFE, 32'h3000});

        // randomized traffic against the scoreboard
        do_reset();
        busy0 = 0; busy1 = 0; slv_pend = 0;
        model_busy = 0; model_last = 1'b1; model_owner = 0;
        mon_en = 1'b1;
        for (int c = 0; c < 3000; c++) rand_cycle(1'b1);
        for (int c = 0; c < 500 && (busy0 || busy1); c++) rand_cycle(1'b0);
        check("drain", {busy1, busy0}, 2'b00);
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
